// File: rtl/readout_sequencer.sv
// Readout sequencer: on a trigger rising edge, walks the channel mux through
// N_CH words, serialising each word MSB-first with optional idle gaps between
// words, then pulses a counter-clear at the end of the frame.
module readout_sequencer #(
  parameter int N_CH   = 16,
  parameter int DATA_W = 12,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic              hold,
  input  logic [DATA_W-1:0] par_in,
  output logic [3:0]        sel,
  output logic              serial_out,
  output logic              word_valid,
  output logic              frame_start,
  output logic              busy,
  output logic              clr,
  output logic              overrun
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [3:0]        gapcnt_q, gapcnt_d;
  logic              trig_q, trig_d;
  logic              overrun_q, overrun_d;
  logic              trig_edge;

  assign trig_edge = trigger & ~trig_q;

  // Next-state logic: frame sequencing, shifting, gap counting, overrun capture
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    gapcnt_d  = gapcnt_q;
    trig_d    = trigger;
    // An edge arriving while a frame is in flight is dropped but remembered.
    overrun_d = overrun_q | (trig_edge & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        sel_d = '0;
        if (trig_edge) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shreg_d  = par_in;
        bitcnt_d = BW'(DATA_W - 1);
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        // hold freezes everything in this state, including the exit decision
        if (!hold) begin
          if (bitcnt_q == '0) begin
            if (sel_q == 4'(N_CH - 1)) begin
              state_d = S_CLEAR;
            end else begin
              sel_d = sel_q + 4'd1;
              if (GAP > 0) begin
                gapcnt_d = 4'(GAP - 1);
                state_d  = S_GAP;
              end else begin
                state_d = S_LOAD;
              end
            end
          end else begin
            shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
            bitcnt_d = bitcnt_q - BW'(1);
          end
        end
      end
      S_GAP: begin
        // Gives the external mux time to settle on the new channel.
        if (gapcnt_q == 4'd0) begin
          state_d = S_LOAD;
        end else begin
          gapcnt_d = gapcnt_q - 4'd1;
        end
      end
      S_CLEAR: begin
        sel_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      gapcnt_q  <= '0;
      trig_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      gapcnt_q  <= gapcnt_d;
      trig_q    <= trig_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs decode directly from registered state so they are glitch-free
  always_comb begin
    sel         = sel_q;
    word_valid  = (state_q == S_SHIFT);
    serial_out  = (state_q == S_SHIFT) ? shreg_q[DATA_W-1] : 1'b0;
    frame_start = (state_q == S_LOAD) && (sel_q == 4'd0);
    busy        = (state_q != S_IDLE);
    clr         = (state_q == S_CLEAR);
    overrun     = overrun_q;
  end

endmodule

// File: tb/tb_readout_sequencer.sv
// Scoreboard bench for readout_sequencer: stimulus pushes expected serial bits
// and frame lengths; a negedge monitor pops and compares them.
module tb_readout_sequencer;

  logic        clk = 1'b0;
  logic        reset, trigger, hold;
  logic [11:0] par_in;
  logic [3:0]  sel;
  logic        serial_out, word_valid, frame_start, busy, clr, overrun;

  // Small instance: N_CH=2, DATA_W=4, GAP=0
  logic        trig2, hold2;
  logic [3:0]  par2;
  logic [3:0]  sel2;
  logic        ser2, wv2, fs2, busy2, clr2, ovr2;

  always #5 clk = ~clk;

  logic [11:0] word_tbl [16] = '{12'hA5C, 12'h3C1, 12'h0F0, 12'h812,
                                 12'hFFF, 12'h000, 12'h5A5, 12'h6B3,
                                 12'h1E4, 12'hC0D, 12'h7E8, 12'h29F,
                                 12'hB46, 12'hD71, 12'h4C2, 12'h93A};
  logic [3:0] small_tbl [2] = '{4'h9, 4'h6};

  assign par_in = word_tbl[sel];
  assign par2   = small_tbl[sel2[0]];

  readout_sequencer dut (
    .clk(clk), .reset(reset), .trigger(trigger), .hold(hold), .par_in(par_in),
    .sel(sel), .serial_out(serial_out), .word_valid(word_valid),
    .frame_start(frame_start), .busy(busy), .clr(clr), .overrun(overrun)
  );

  readout_sequencer #(.N_CH(2), .DATA_W(4), .GAP(0)) dut_small (
    .clk(clk), .reset(reset), .trigger(trig2), .hold(hold2), .par_in(par2),
    .sel(sel2), .serial_out(ser2), .word_valid(wv2),
    .frame_start(fs2), .busy(busy2), .clr(clr2), .overrun(ovr2)
  );

  int total = 0;
  int bad   = 0;
  bit exp_bits[$];
  int exp_len[$];
  int frames = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: frame length, clr pulse width, serial bits, hold freeze
  int  cnt = 0;
  bit  counting = 0, after_clr = 0, prev_hold = 0, held_bit = 0;
  always @(negedge clk) begin
    if (reset) begin
      counting  = 0;
      after_clr = 0;
      prev_hold = 0;
    end else begin
      if (after_clr) begin
        check("clr_width", 32'(clr), 32'd0);
        check("busy_after_clr", 32'(busy), 32'd0);
        after_clr = 0;
      end
      if (frame_start) begin
        frames++;
        counting = 1;
        cnt = 0;
      end
      if (counting) cnt++;
      if (clr) begin
        if (exp_len.size() == 0) check("clr_unexpected", 32'd1, 32'd0);
        else check("frame_len", 32'(cnt), 32'(exp_len.pop_front()));
        counting  = 0;
        after_clr = 1;
      end
      if (word_valid) begin
        if (prev_hold) check("hold_frozen", 32'(serial_out), 32'(held_bit));
        if (hold) begin
          held_bit  = serial_out;
          prev_hold = 1;
        end else begin
          prev_hold = 0;
          if (exp_bits.size() == 0) check("bit_unexpected", 32'd1, 32'd0);
          else check("serial_bit", 32'(serial_out), 32'(exp_bits.pop_front()));
        end
      end else begin
        prev_hold = 0;
        check("serial_idle", 32'(serial_out), 32'd0);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(int len);
    for (int ch = 0; ch < 16; ch++)
      for (int b = 11; b >= 0; b--)
        exp_bits.push_back(word_tbl[ch][b]);
    exp_len.push_back(len);
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
  endtask

  task automatic wait_idle(string name);
    bit ok = 0;
    for (int i = 0; i < 600; i++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    if (!ok) check(name, 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_word_valid"}, 32'(word_valid), 32'd0);
    check({tag, "_serial_out"}, 32'(serial_out), 32'd0);
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_clr"}, 32'(clr), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    int f0;
    int n;
    int clrcnt;
    logic [7:0] bits2;
    logic [3:0] sel_rec [64];
    bit found;

    reset = 1'b1; trigger = 1'b0; hold = 1'b0; trig2 = 1'b0; hold2 = 1'b0;
    tick(3);
    reset = 1'b0;
    check_all_zero("reset");

    // Basic frame: A5C first word, 224-cycle frame
    f0 = frames;
    push_frame(224);
    pulse_trigger();
    wait_idle("basic_timeout");
    tick(3);
    check("basic_frames", 32'(frames - f0), 32'd1);
    check("basic_overrun", 32'(overrun), 32'd0);
    check("basic_bits_left", 32'(exp_bits.size()), 32'd0);

    // Hold for 5 cycles in the middle of word 3: frame stretches to 229
    f0 = frames;
    push_frame(229);
    pulse_trigger();
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (sel == 4'd3 && word_valid) begin
        found = 1;
        break;
      end
      tick(1);
    end
    if (!found) check("hold_word3_timeout", 32'd0, 32'd1);
    tick(4);
    hold = 1'b1;
    tick(5);
    hold = 1'b0;
    wait_idle("hold_timeout");
    tick(3);
    check("hold_frames", 32'(frames - f0), 32'd1);
    check("hold_bits_left", 32'(exp_bits.size()), 32'd0);

    // Second trigger edge mid-frame: overrun sets, frame unaffected
    f0 = frames;
    push_frame(224);
    pulse_trigger();
    tick(98);
    pulse_trigger();
    check("overrun_set", 32'(overrun), 32'd1);
    wait_idle("overrun_timeout");
    tick(5);
    check("overrun_sticky", 32'(overrun), 32'd1);
    check("overrun_frames", 32'(frames - f0), 32'd1);
    check("overrun_busy", 32'(busy), 32'd0);

    // Reset mid-frame: abort with no clr, then a fresh frame completes
    push_frame(224);
    pulse_trigger();
    tick(49);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_bits.delete();
    exp_len.delete();
    check_all_zero("midreset");
    tick(5);
    check("midreset_idle", 32'(busy), 32'd0);
    f0 = frames;
    push_frame(224);
    pulse_trigger();
    wait_idle("midreset_timeout");
    tick(3);
    check("midreset_frames", 32'(frames - f0), 32'd1);

    // Trigger stuck high across reset release: exactly one frame
    trigger = 1'b1;
    reset = 1'b1;
    tick(2);
    f0 = frames;
    push_frame(224);
    reset = 1'b0;
    tick(1);
    check("stuck_started", 32'(busy), 32'd1);
    wait_idle("stuck_timeout");
    tick(30);
    check("stuck_busy", 32'(busy), 32'd0);
    check("stuck_frames", 32'(frames - f0), 32'd1);
    trigger = 1'b0;
    tick(2);

    // Small instance: 2 channels of 4 bits, no gap -> 11-cycle frame
    trig2 = 1'b1;
    tick(1);
    trig2 = 1'b0;
    n = 0;
    clrcnt = 0;
    bits2 = '0;
    while (busy2 && n < 50) begin
      sel_rec[n] = sel2;
      if (wv2) bits2 = {bits2[6:0], ser2};
      if (clr2) clrcnt++;
      n++;
      tick(1);
    end
    check("small_len", 32'(n), 32'd11);
    check("small_sel_first", 32'(sel_rec[0]), 32'd0);
    check("small_sel_word1", 32'(sel_rec[5]), 32'd1);
    check("small_sel_clear", 32'(sel_rec[10]), 32'd1);
    check("small_sel_idle", 32'(sel2), 32'd0);
    check("small_bits", 32'(bits2), 32'h96);
    check("small_clr_count", 32'(clrcnt), 32'd1);

    check("final_bits_left", 32'(exp_bits.size()), 32'd0);
    check("final_len_left", 32'(exp_len.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
